// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filter (fir_seq_mac).
// Contents:
//   fir_state_t - sequencer states IDLE / MAC / SCALE / OUT
//   clog2       - ceiling log2, used to size tap indices
//   acc_width   - accumulator width that cannot overflow for NTAPS taps
//   prod_width  - width of the accumulator * gain product
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } fir_state_t;

    // Smallest r such that 2**r >= value
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // NTAPS products of DW x CW bits need clog2(NTAPS) guard bits
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + clog2(ntaps);
    endfunction

    // Signed accumulator times gain zero-extended by one bit
    function automatic int prod_width(input int aw, input int gw);
        return aw + gw + 1;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Runtime-loadable coefficient register file for fir_seq_mac.
// Writes are only legal while the sequencer is idle and the address is in
// range; any other write is discarded and flagged with a one-cycle coef_err.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset (clears all coefficients)
//   idle         - high while the sequencer is in IDLE
//   coef_we      - write strobe
//   coef_addr    - tap index to write
//   coef_data    - signed coefficient value
//   rd_idx       - tap index for the combinational read port
//   rd_data      - coefficient at rd_idx
//   coef_err     - registered pulse for a dropped write
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NTAPS = 29,
    parameter int CW    = 11,
    parameter int IW    = clog2(NTAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 idle,
    input  logic                 coef_we,
    input  logic [IW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    input  logic [IW-1:0]        rd_idx,
    output logic signed [CW-1:0] rd_data,
    output logic                 coef_err
);

    logic signed [CW-1:0] coefs [NTAPS];
    logic                 write_ok;

    // A write lands only when idle and addressed inside the tap range
    assign write_ok = coef_we && idle && (32'(coef_addr) < NTAPS);

    // Storage and error flag; every rejected strobe raises coef_err for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                coefs[i] <= '0;
            end
            coef_err <= 1'b0;
        end else begin
            coef_err <= coef_we && !write_ok;
            if (write_ok) begin
                coefs[coef_addr] <= coef_data;
            end
        end
    end

    // The sequencer only ever presents indices below NTAPS
    assign rd_data = coefs[rd_idx];

endmodule

// File: rtl/fir_seq_mac.sv
// Time-multiplexed FIR filter: one multiplier, one tap product per cycle.
// A sample accepted in IDLE is shifted into the delay line, NTAPS MAC cycles
// build the accumulator, SCALE applies gain and SHIFT, OUT holds the result
// until the consumer takes it.
// Optional feature macro: FIR_SEQ_MAC_SATURATE_EN
//   defined   - scaled result is saturated to the OW-bit signed range
//   undefined - scaled result wraps to its low OW bits
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   in_valid/in_ready/din - sample input handshake and signed sample
//   out_valid/out_ready   - result handshake
//   dout                  - signed filtered result, stable while out_valid
//   gain                  - unsigned gain, sampled at the SCALE edge
//   coef_we/coef_addr/coef_data - coefficient write port
//   coef_err              - one-cycle pulse when a coefficient write is dropped
module fir_seq_mac
    import fir_pkg::*;
#(
    parameter int NTAPS = 29,
    parameter int DW    = 8,
    parameter int CW    = 11,
    parameter int GW    = 8,
    parameter int OW    = 20,
    parameter int SHIFT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DW-1:0]          din,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OW-1:0]          dout,
    input  logic [GW-1:0]                 gain,
    input  logic                          coef_we,
    input  logic [clog2(NTAPS)-1:0]       coef_addr,
    input  logic signed [CW-1:0]          coef_data,
    output logic                          coef_err
);

    localparam int IW = clog2(NTAPS);
    localparam int AW = acc_width(DW, CW, NTAPS);
    localparam int PW = prod_width(AW, GW);
    localparam int MW = DW + CW;

    fir_state_t           state;
    logic [IW-1:0]        idx;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] x [NTAPS];

    logic signed [CW-1:0] coef_rd;
    logic signed [DW-1:0] x_sel;
    logic signed [MW-1:0] term;
    logic signed [AW-1:0] term_ext;
    logic signed [PW-1:0] prod_full;
    logic signed [OW-1:0] scaled;

    assign in_ready = (state == IDLE);

    fir_coef_bank #(
        .NTAPS (NTAPS),
        .CW    (CW),
        .IW    (IW)
    ) u_coef_bank (
        .clk       (clk),
        .rst       (rst),
        .idle      (state == IDLE),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .rd_idx    (idx),
        .rd_data   (coef_rd),
        .coef_err  (coef_err)
    );

    // Single shared multiplier: operands are sign-extended to the full product width
    assign x_sel    = x[idx];
    assign term     = $signed({{DW{coef_rd[CW-1]}}, coef_rd}) * $signed({{CW{x_sel[DW-1]}}, x_sel});
    assign term_ext = {{(AW-MW){term[MW-1]}}, term};

    // Gain is treated as a non-negative signed operand; PW bits hold the exact product
    assign prod_full = $signed({{(GW+1){acc[AW-1]}}, acc}) * $signed({{(AW+1){1'b0}}, gain});

`ifdef FIR_SEQ_MAC_SATURATE_EN
    logic signed [PW-1:0] p;
    assign p = prod_full >>> SHIFT;

    // In range exactly when all bits from OW-1 upward agree with the sign
    always_comb begin
        scaled = p[OW-1:0];
        if (!((&p[PW-1:OW-1]) || !(|p[PW-1:OW-1]))) begin
            scaled = p[PW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
    end
`else
    assign scaled = OW'(prod_full >>> SHIFT);
`endif

    // Sequencer: accept, accumulate NTAPS products, scale, hold for the consumer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                x[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x[0] <= din;
                        for (int k = 1; k < NTAPS; k++) begin
                            x[k] <= x[k-1];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + term_ext;
                    if (idx == IW'(NTAPS - 1)) begin
                        state <= SCALE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                SCALE: begin
                    dout      <= scaled;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fir_seq_mac.md
# fir_seq_mac

Time-multiplexed, parametrised FIR filter. It is the multi-bit successor of the filter family's single-bit, fixed-29-tap direct-form design. A single multiplier computes one tap product per cycle. Coefficients are runtime-loadable and symmetric-agnostic. Valid/ready handshakes sit on both sample ports, and a post-accumulation gain stage replaces the old combinational output multiply and clamp.

## Interface
Parameters:
- NTAPS, 29: number of taps (≥2).
- DW, 8: input sample width, signed.
- CW, 11: coefficient width, signed.
- GW, 8: gain width, unsigned.
- OW, 20: output width, signed.
- SHIFT, 0: arithmetic right shift applied after gain.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- din  in  DW  signed sample
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- dout  out  OW  signed filtered result
- gain  in  GW  output gain, sampled at the scale step
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAPS)  tap index
- coef_data  in  CW  signed coefficient
- coef_err  out  1  one-cycle pulse: write dropped

## Operation
- FSM states: IDLE, MAC, SCALE, OUT.
- **IDLE**
  - in_ready=1.
  - On in_valid: shift din into the delay line (x[0]=din, x[k]=x[k-1]), clear acc, set idx=0, go to MAC.
- **MAC**
  - Each cycle: acc += coef[idx]*x[idx]; idx++.
  - After the product for idx=NTAPS-1, go to SCALE.
- **SCALE**
  - p = (acc * $signed({1'b0,gain})) >>> SHIFT.
  - Reduce p to OW bits (see Configuration), register it into dout.
  - Set out_valid=1, go to OUT.
- **OUT**
  - Hold dout and out_valid until out_ready; then clear out_valid and go to IDLE.
- Widths:
  - acc is AW = DW+CW+clog2(NTAPS) bits, signed; it never overflows.
  - p is AW+GW+1 bits.
- Coefficient writes:
  - Honoured only in IDLE; take effect on the next sample.
  - A write in any other state is dropped and coef_err pulses for one cycle.
  - A write to coef_addr ≥ NTAPS is dropped and pulses coef_err.
- A write in IDLE coincident with an accepted sample is honoured; that sample already uses the new coefficient.
- dout is stable whenever out_valid=1.

## Timing
- Reset values:
  - state=IDLE.
  - in_ready=1 (decoded from state).
  - out_valid=0, dout=0, coef_err=0.
  - Delay line all 0; all coefficients 0.
- Latency:
  - Sample accepted at edge E0 gives out_valid high after edge E(NTAPS+1).
  - MAC occupies edges E1..E(NTAPS); SCALE is edge E(NTAPS+1).
- Throughput with out_ready tied high: one sample per NTAPS+3 cycles.
- Reset asserted mid-operation:
  - Returns to IDLE immediately and clears the delay line, acc and dout.
  - Coefficients are also cleared and must be reloaded.
- gain is sampled only at the SCALE edge; changes at other times have no effect on the in-flight result.

## Configuration
- Macro: FIR_SEQ_MAC_SATURATE_EN.
- Defined: p is saturated to [-2^(OW-1), 2^(OW-1)-1].
- Undefined: dout = p[OW-1:0] (two's-complement wrap). No clamp logic is built.

## Structure
- Package fir_pkg holds:
  - The FSM state enum (IDLE/MAC/SCALE/OUT).
  - A clog2 constant function.
  - Accumulator and product width localparam helpers.
- Sub-module fir_coef_bank is natural:
  - NTAPS×CW register file with write port, write-legality check and coef_err generation.
  - Combinational read by idx.

## Test plan
All scenarios use NTAPS=4, DW=8, CW=8, GW=8, OW=16, SHIFT=0.
1. Coefs 1,2,3,4; gain 1; samples 1,0,0,0,0 -> dout 1,2,3,4,0.
2. Latency and backpressure:
   - Sample accepted at E0 -> out_valid after E5.
   - Hold out_ready=0 for 5 cycles -> dout stable, in_ready=0, a concurrent in_valid is not accepted.
3. Coefs all 127; gain 255; four samples of 127 -> fourth output:
   - 32767 with the macro defined.
   - 2044 (16451580 mod 65536) with the macro undefined.
4. Coefs 1,2,3,4; write coef[0]=9 during MAC:
   - coef_err pulses one cycle.
   - Current and next outputs still use coef[0]=1.
   - A write in IDLE then takes effect.
5. Assert rst during MAC:
   - out_valid=0, in_ready=1, dout=0.
   - After reloading coefs 1,2,3,4, an impulse gives dout 1,2,3,4 with no residue.
6. Coefs -1,0,0,0; gain 2; SHIFT=1; sample -128 -> dout 128. Then sample 5 -> dout -5.
